// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared combinational ALU: round-robin grant,
// lock-based exclusive ownership, a one-cycle registered response and an NZVC flag register.
module alu_arbiter #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req0_op,
    input  logic [2:0]       req1_op,
    input  logic             req0_setflags,
    input  logic             req1_setflags,
    input  logic             req0_lock,
    input  logic             req1_lock,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic             stall,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_negative,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    input  logic             alu_carry_out,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             carry_out
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    state_t r_state;
    logic   r_rr;
    logic   w_gnt0;
    logic   w_gnt1;
    logic   w_accept;
    logic   w_id;
    logic   w_setflags;
    logic   w_lock;

    // Grant selection: round-robin in IDLE, owner-only while locked
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req0_valid && req1_valid) begin
                    if (r_rr) begin
                        w_gnt1 = 1'b1;
                    end else begin
                        w_gnt0 = 1'b1;
                    end
                end else if (req0_valid) begin
                    w_gnt0 = 1'b1;
                end else if (req1_valid) begin
                    w_gnt1 = 1'b1;
                end else begin
                    w_gnt0 = 1'b0;
                    w_gnt1 = 1'b0;
                end
            end
            ST_OWN0: w_gnt0 = req0_valid;
            ST_OWN1: w_gnt1 = req1_valid;
            default: begin
                w_gnt0 = 1'b0;
                w_gnt1 = 1'b0;
            end
        endcase
    end

    assign req0_ready = w_gnt0 & req0_valid & ~stall;
    assign req1_ready = w_gnt1 & req1_valid & ~stall;
    assign w_accept   = req0_ready | req1_ready;
    assign w_id       = req1_ready;
    assign w_setflags = w_id ? req1_setflags : req0_setflags;
    assign w_lock     = w_id ? req1_lock : req0_lock;

    // Requester 0 drives the ALU whenever requester 1 is not the granted one
    assign alu_a  = w_gnt1 ? req1_a  : req0_a;
    assign alu_b  = w_gnt1 ? req1_b  : req0_b;
    assign alu_op = w_gnt1 ? req1_op : req0_op;

    // Ownership FSM, round-robin pointer, response and flag registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_rr      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
            negative  <= 1'b0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            carry_out <= 1'b0;
        end else begin
            rsp_valid <= w_accept;
            if (w_accept) begin
                rsp_id   <= w_id;
                rsp_data <= alu_result;
                if (w_setflags) begin
                    negative  <= alu_negative;
                    zero      <= alu_zero;
                    overflow  <= alu_overflow;
                    carry_out <= alu_carry_out;
                end
            end
            // A stalled cycle freezes ownership and the pointer
            if (!stall) begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_accept) begin
                            r_rr <= ~w_id;
                            if (w_lock) begin
                                r_state <= w_id ? ST_OWN1 : ST_OWN0;
                            end
                        end
                    end
                    ST_OWN0: begin
                        if (!req0_lock) begin
                            r_state <= ST_IDLE;
                            r_rr    <= 1'b1;
                        end
                    end
                    ST_OWN1: begin
                        if (!req1_lock) begin
                            r_state <= ST_IDLE;
                            r_rr    <= 1'b0;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed-vector bench for alu_arbiter with a response scoreboard and a behavioural ALU.
module tb_alu_arbiter;

    localparam int W = 64;

    logic         clk;
    logic         reset;
    logic         req0_valid, req1_valid;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]   req0_op, req1_op;
    logic         req0_setflags, req1_setflags;
    logic         req0_lock, req1_lock;
    logic         req0_ready, req1_ready;
    logic         stall;
    logic [W-1:0] alu_a, alu_b;
    logic [2:0]   alu_op;
    logic [W-1:0] alu_result;
    logic         alu_negative, alu_zero, alu_overflow, alu_carry_out;
    logic         rsp_valid, rsp_id;
    logic [W-1:0] rsp_data;
    logic         negative, zero, overflow, carry_out;

    typedef struct packed {
        logic         id;
        logic [W-1:0] data;
    } rsp_t;

    rsp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    localparam logic [2:0]   OP_ADD = 3'd0;
    localparam logic [2:0]   OP_SUB = 3'd1;
    localparam logic [W-1:0] ALL1   = {W{1'b1}};

    alu_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_op(req0_op), .req1_op(req1_op),
        .req0_setflags(req0_setflags), .req1_setflags(req1_setflags),
        .req0_lock(req0_lock), .req1_lock(req1_lock),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .stall(stall),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_negative(alu_negative), .alu_zero(alu_zero),
        .alu_overflow(alu_overflow), .alu_carry_out(alu_carry_out),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .negative(negative), .zero(zero), .overflow(overflow), .carry_out(carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared ALU stand-in: add, subtract, otherwise bitwise AND
    always_comb begin
        logic [W:0] sum;
        sum = '0;
        case (alu_op)
            OP_ADD:  sum = {1'b0, alu_a} + {1'b0, alu_b};
            OP_SUB:  sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {{W{1'b0}}, 1'b1};
            default: sum = {1'b0, alu_a & alu_b};
        endcase
        alu_result    = sum[W-1:0];
        alu_carry_out = sum[W];
        alu_negative  = sum[W-1];
        alu_zero      = (sum[W-1:0] == '0);
        if (alu_op == OP_SUB) begin
            alu_overflow = (alu_a[W-1] != alu_b[W-1]) && (sum[W-1] != alu_a[W-1]);
        end else begin
            alu_overflow = (alu_a[W-1] == alu_b[W-1]) && (sum[W-1] != alu_a[W-1]);
        end
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0b required=%0b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk64(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every response pulse must match the oldest expected response
    always @(negedge clk) begin
        if (reset && rsp_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp actual=id%0b/%0h required=none t=%0t", rsp_id, rsp_data, $time);
            end else begin
                rsp_t e;
                e = sb_q.pop_front();
                chk1("rsp_id", rsp_id, e.id);
                chk64("rsp_data", rsp_data, e.data);
            end
        end
    end

    task automatic set0(input logic v, input logic lk, input logic sf, input logic [2:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b);
        req0_valid = v; req0_lock = lk; req0_setflags = sf; req0_op = op; req0_a = a; req0_b = b;
    endtask

    task automatic set1(input logic v, input logic lk, input logic sf, input logic [2:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b);
        req1_valid = v; req1_lock = lk; req1_setflags = sf; req1_op = op; req1_a = a; req1_b = b;
    endtask

    // Inputs are applied 3 time units after a rising edge; check readies, queue response, commit
    task automatic step(input logic er0, input logic er1, input logic [W-1:0] edata);
        #1;
        chk1("req0_ready", req0_ready, er0);
        chk1("req1_ready", req1_ready, er1);
        if (er0 || er1) begin
            sb_q.push_back({er1, edata});
        end
        @(posedge clk);
        #3;
    endtask

    initial begin
        reset = 1'b0;
        stall = 1'b0;
        set0(1'b0, 1'b0, 1'b0, OP_ADD, 64'd0, 64'd0);
        set1(1'b0, 1'b0, 1'b0, OP_ADD, 64'd0, 64'd0);
        #2;
        chk1("reset_rsp_valid", rsp_valid, 1'b0);
        chk64("reset_rsp_data", rsp_data, 64'd0);
        chk1("reset_negative", negative, 1'b0);
        chk1("reset_zero", zero, 1'b0);
        @(posedge clk);
        #3;
        reset = 1'b1;

        // Round-robin alternation with both requesters valid
        set0(1'b1, 1'b0, 1'b0, OP_ADD, 64'd5, 64'd3);
        set1(1'b1, 1'b0, 1'b0, OP_ADD, 64'd10, 64'd1);
        step(1'b1, 1'b0, 64'd8);
        step(1'b0, 1'b1, 64'd11);
        step(1'b1, 1'b0, 64'd8);
        step(1'b0, 1'b1, 64'd11);

        // Flag load on setflags, hold without it
        set0(1'b1, 1'b0, 1'b1, OP_SUB, 64'd0, 64'd1);
        set1(1'b0, 1'b0, 1'b0, OP_ADD, 64'd10, 64'd1);
        step(1'b1, 1'b0, ALL1);
        chk1("flag_n_set", negative, 1'b1);
        chk1("flag_z_set", zero, 1'b0);
        set0(1'b0, 1'b0, 1'b0, OP_ADD, 64'd5, 64'd3);
        set1(1'b1, 1'b0, 1'b0, OP_ADD, 64'd10, 64'd1);
        step(1'b0, 1'b1, 64'd11);
        chk1("flag_n_hold", negative, 1'b1);
        chk1("flag_z_hold", zero, 1'b0);

        // Move pointer to requester 1, then lock ownership by requester 1
        set0(1'b1, 1'b0, 1'b0, OP_ADD, 64'd5, 64'd3);
        set1(1'b0, 1'b0, 1'b0, OP_ADD, 64'd10, 64'd1);
        step(1'b1, 1'b0, 64'd8);
        set1(1'b1, 1'b1, 1'b0, OP_ADD, 64'd10, 64'd1);
        step(1'b0, 1'b1, 64'd11);
        step(1'b0, 1'b1, 64'd11);
        step(1'b0, 1'b1, 64'd11);
        req1_lock = 1'b0;
        step(1'b0, 1'b1, 64'd11);
        step(1'b1, 1'b0, 64'd8);

        // Stall blocks grants and freezes pointer and flags
        stall = 1'b1;
        step(1'b0, 1'b0, 64'd0);
        step(1'b0, 1'b0, 64'd0);
        chk1("stall_flag_n", negative, 1'b1);
        stall = 1'b0;
        step(1'b0, 1'b1, 64'd11);
        step(1'b1, 1'b0, 64'd8);

        // Ownership by requester 0, idle owner keeps requester 1 out, then reset mid-response
        set1(1'b0, 1'b0, 1'b0, OP_ADD, 64'd10, 64'd1);
        set0(1'b1, 1'b1, 1'b0, OP_ADD, 64'd5, 64'd3);
        step(1'b1, 1'b0, 64'd8);
        set0(1'b0, 1'b1, 1'b0, OP_ADD, 64'd5, 64'd3);
        set1(1'b1, 1'b0, 1'b0, OP_ADD, 64'd10, 64'd1);
        step(1'b0, 1'b0, 64'd0);
        set0(1'b1, 1'b1, 1'b1, OP_SUB, 64'd0, 64'd1);
        step(1'b1, 1'b0, ALL1);
        chk1("pre_reset_rsp_valid", rsp_valid, 1'b1);
        reset = 1'b0;
        sb_q.delete();
        #1;
        chk1("midreset_rsp_valid", rsp_valid, 1'b0);
        chk64("midreset_rsp_data", rsp_data, 64'd0);
        chk1("midreset_negative", negative, 1'b0);
        chk1("midreset_rsp_id", rsp_id, 1'b0);
        set0(1'b0, 1'b0, 1'b0, OP_ADD, 64'd5, 64'd3);
        set1(1'b0, 1'b0, 1'b0, OP_ADD, 64'd10, 64'd1);
        @(posedge clk);
        #3;
        reset = 1'b1;
        set1(1'b1, 1'b0, 1'b0, OP_ADD, 64'd10, 64'd1);
        step(1'b0, 1'b1, 64'd11);
        set1(1'b0, 1'b0, 1'b0, OP_ADD, 64'd10, 64'd1);
        repeat (3) @(posedge clk);
        #3;
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL missing_rsp actual=%0d pending required=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 64, datapath operand/result width.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on posedge clk.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have ports req0_valid, req1_valid  input  1 each  request present.
REQ-005 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  WIDTH each  operands.
REQ-006 SHALL have ports req0_op, req1_op  input  3 each  ALU op code.
REQ-007 SHALL have ports req0_setflags, req1_setflags  input  1 each  update NZVC on acceptance.
REQ-008 SHALL have ports req0_lock, req1_lock  input  1 each  request exclusive ownership.
REQ-009 SHALL have ports req0_ready, req1_ready  output  1 each  request accepted this cycle.
REQ-010 SHALL have port stall  input  1  blocks all grants while high.
REQ-011 SHALL have ports alu_a, alu_b  output  WIDTH  operands to the shared ALU; alu_op  output  3.
REQ-012 SHALL have ports alu_result  input  WIDTH; alu_negative, alu_zero, alu_overflow, alu_carry_out  input  1 each  combinational ALU outputs.
REQ-013 SHALL have ports rsp_valid  output  1; rsp_id  output  1; rsp_data  output  WIDTH  registered response.
REQ-014 SHALL have ports negative, zero, overflow, carry_out  output  1 each  architectural flag register.

Function
REQ-015 SHALL accept at most one request per cycle; accept = reqN_valid & reqN_ready.
REQ-016 SHALL assert reqN_ready combinationally only when N is granted, reqN_valid=1 and stall=0; never both readies high.
REQ-017 SHALL drive alu_a/alu_b/alu_op from the granted requester; from requester 0 when none granted.
REQ-018 SHALL register alu_result into rsp_data, N into rsp_id, and pulse rsp_valid for exactly one cycle, the cycle after acceptance (latency 1, no response backpressure).
REQ-019 SHALL load NZVC from alu_* on posedge after an acceptance with setflags=1; otherwise hold flags.
REQ-020 SHALL implement FSM states IDLE, OWN0, OWN1.
REQ-021 IDLE: grant by round-robin pointer rr; if only one valid, grant it; if both valid, grant rr.
REQ-022 IDLE: on acceptance of N, rr <= ~N; if reqN_lock=1 at acceptance, next state OWNN.
REQ-023 OWNN: only N may be granted; other requester ready=0 regardless of valid.
REQ-024 OWNN: when reqN_lock=0, return to IDLE next cycle; a concurrent valid from N is still accepted that cycle as the final beat; rr <= ~N.
REQ-025 OWNN with reqN_valid=0 and lock=1: remain OWNN, no grant.
REQ-026 stall=1: no acceptance, FSM state, rr, flags unchanged; rsp_valid from prior cycle's acceptance still pulses.
REQ-027 SHALL not modify rsp_data or rsp_id in cycles without an acceptance.

Reset
REQ-028 reset=0 SHALL immediately force: state IDLE, rr=0, rsp_valid=0, rsp_id=0, rsp_data=0, negative=zero=overflow=carry_out=0.
REQ-029 Reset asserted mid-ownership or mid-response SHALL abandon the transaction; no rsp_valid pulse after reset release without a new acceptance.
REQ-030 First cycle after reset release SHALL arbitrate normally from IDLE with rr=0.

Verification
REQ-031 Both valid, no lock, 4 cycles, ALU add, req0 a=5 b=3, req1 a=10 b=1 -> accepts alternate 0,1,0,1; rsp_data 8,11,8,11 one cycle later; rsp_id matches.
REQ-032 req1 valid with lock=1 for 3 cycles while req0 valid -> req1 accepted 3 consecutive cycles, req0_ready=0; lock drops -> req1 final beat accepted, req0 accepted next cycle.
REQ-033 req0 setflags=1, subtract a=0 b=1 -> next cycle negative=1 zero=0; subsequent req1 setflags=0 add -> flags unchanged.
REQ-034 stall=1 with both valid for 2 cycles -> both ready=0, rr and flags unchanged; stall=0 -> grant resumes at rr.
REQ-035 reset=0 asserted during OWN0 with rsp_valid=1 -> all outputs zero immediately; after release req1 alone valid -> accepted first cycle.
